// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared 32-bit SLL/SRL/SRA unit.
// The result is held in a single registered output stage with valid/ready backpressure.
module shift_arbiter #(
    parameter int DW  = 32,
    parameter int SAW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [4:0]     req0_fs,
    input  logic [SAW-1:0] req0_shamt,
    input  logic [DW-1:0]  req0_data,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [4:0]     req1_fs,
    input  logic [SAW-1:0] req1_shamt,
    input  logic [DW-1:0]  req1_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic           out_c,
    output logic           out_id,
    output logic           out_err
);

    localparam logic [4:0] FS_SLL = 5'h0C;
    localparam logic [4:0] FS_SRL = 5'h0D;
    localparam logic [4:0] FS_SRA = 5'h0E;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            c_q, c_d;
    logic            id_q, id_d;
    logic            err_q, err_d;

    logic            can_load;
    logic            grant0, grant1;
    logic            accept;
    logic [4:0]      sel_fs;
    logic [SAW-1:0]  sel_shamt;
    logic [DW-1:0]  sel_data;
    logic [DW:0]     sll_ext;
    logic [DW:0]     srl_ext;
    logic [DW-1:0]   sra_res;

    // Handshakes are suppressed while reset is high so nothing looks accepted.
    always_comb begin
        can_load   = ~reset & ((state_q == EMPTY) | out_ready);
        grant0     = req0_valid & (~req1_valid | ~ptr_q);
        grant1     = req1_valid & (~req0_valid |  ptr_q);
        req0_ready = grant0 & can_load;
        req1_ready = grant1 & can_load;
        accept     = req0_ready | req1_ready;
        sel_fs     = grant1 ? req1_fs    : req0_fs;
        sel_shamt  = grant1 ? req1_shamt : req0_shamt;
        sel_data   = grant1 ? req1_data  : req0_data;
    end

    // One extra bit on each side captures the last bit shifted out as the carry.
    always_comb begin
        sll_ext = {1'b0, sel_data} << sel_shamt;
        srl_ext = {sel_data, 1'b0} >> sel_shamt;
        sra_res = $signed(sel_data) >>> sel_shamt;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        c_d     = c_q;
        id_d    = id_q;
        err_d   = err_q;
        if (accept) begin
            state_d = FULL;
            ptr_d   = ~grant1;
            id_d    = grant1;
            data_d  = '0;
            c_d     = 1'b0;
            err_d   = 1'b0;
            case (sel_fs)
                FS_SLL: begin
                    data_d = sll_ext[DW-1:0];
                    c_d    = sll_ext[DW];
                end
                FS_SRL: begin
                    data_d = srl_ext[DW:1];
                    c_d    = srl_ext[0];
                end
                FS_SRA: data_d = sra_res;
                default: err_d = 1'b1;
            endcase
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            c_q     <= 1'b0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            c_q     <= c_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_c     = c_q;
    assign out_id    = id_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of arbitration and shifting.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_fs, req1_fs;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [31:0] req0_data, req1_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_c, out_id, out_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid;
    logic        m_ptr;
    logic [31:0] m_data;
    logic        m_c, m_id, m_err;

    shift_arbiter #(.DW(32), .SAW(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fs(req0_fs),
        .req0_shamt(req0_shamt), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fs(req1_fs),
        .req1_shamt(req1_shamt), .req1_data(req1_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_c(out_c), .out_id(out_id), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Shifts expressed as multiplication/division by powers of two.
    function automatic void ref_shift(input logic [4:0] fs, input logic [4:0] n,
                                      input logic [31:0] t, output logic [31:0] d,
                                      output logic c, output logic e);
        longint unsigned tt, p2, r;
        tt = 64'(t);
        p2 = 64'd1 << n;
        d = '0; c = 1'b0; e = 1'b0;
        case (fs)
            5'h0C: begin
                r = tt * p2;
                d = r[31:0];
                c = (n != 0) ? r[32] : 1'b0;
            end
            5'h0D: begin
                d = 32'(tt / p2);
                r = (n != 0) ? (tt / (p2 / 2)) % 2 : 64'd0;
                c = r[0];
            end
            5'h0E: begin
                if (t[31]) d = ~32'(((~tt) & 64'hFFFF_FFFF) / p2);
                else       d = 32'(tt / p2);
            end
            default: e = 1'b1;
        endcase
    endfunction

    function automatic int model_winner();
        logic can;
        can = !m_valid || out_ready;
        if (reset || !can) return -1;
        if (req0_valid && req1_valid) return m_ptr ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_ptr = 1'b0;
        m_data = '0; m_c = 1'b0; m_id = 1'b0; m_err = 1'b0;
    endtask

    task automatic set_in(input logic v0, input logic [4:0] f0, input logic [4:0] s0,
                          input logic [31:0] d0, input logic v1, input logic [4:0] f1,
                          input logic [4:0] s1, input logic [31:0] d1, input logic ordy);
        req0_valid = v0; req0_fs = f0; req0_shamt = s0; req0_data = d0;
        req1_valid = v1; req1_fs = f1; req1_shamt = s1; req1_data = d1;
        out_ready = ordy;
    endtask

    // Advance one rising edge and update the model from the inputs seen at that edge.
    task automatic edge_model();
        int win;
        logic ordy;
        win  = model_winner();
        ordy = out_ready;
        @(posedge clk);
        if (win == 0) begin
            ref_shift(req0_fs, req0_shamt, req0_data, m_data, m_c, m_err);
            m_valid = 1'b1; m_id = 1'b0; m_ptr = 1'b1;
        end else if (win == 1) begin
            ref_shift(req1_fs, req1_shamt, req1_data, m_data, m_c, m_err);
            m_valid = 1'b1; m_id = 1'b1; m_ptr = 1'b0;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        set_in(1, 5'h0C, 1, 32'h1, 1, 5'h0C, 1, 32'h1, 1);
        #1;
        checks++;
        if ({out_valid, out_data, out_c, out_id, out_err} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%0b d=%h c=%0b id=%0b err=%0b, want all zero",
                     out_valid, out_data, out_c, out_id, out_err);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_sll();
        logic [31:0] td [2] = '{32'h8000_0001, 32'h0000_0001};
        logic [4:0]  tn [2] = '{5'd1, 5'd31};
        logic [31:0] ed [2] = '{32'h0000_0002, 32'h8000_0000};
        logic        ec [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(1, 5'h0C, tn[i], td[i], 0, 0, 0, 0, 1);
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sll_ready%0d: got %b, want 1", i, req0_ready);
            end
            edge_model();
            checks++;
            if ({out_valid, out_data, out_c, out_id, out_err} !== {1'b1, ed[i], ec[i], 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL sll_result%0d: got v=%0b d=%h c=%0b id=%0b err=%0b, want v=1 d=%h c=%0b id=0 err=0",
                         i, out_valid, out_data, out_c, out_id, out_err, ed[i], ec[i]);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        edge_model();
    endtask

    task automatic test_srl_sra();
        logic [4:0]  tf [3] = '{5'h0D, 5'h0E, 5'h0E};
        logic [31:0] td [3] = '{32'h0000_0003, 32'h8000_0000, 32'h4000_0000};
        logic [4:0]  tn [3] = '{5'd1, 5'd31, 5'd4};
        logic [31:0] ed [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0400_0000};
        logic        ec [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 1, tf[i], tn[i], td[i], 1);
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL right_ready%0d: got %b, want 01", i, {req0_ready, req1_ready});
            end
            edge_model();
            checks++;
            if ({out_valid, out_data, out_c, out_id, out_err} !== {1'b1, ed[i], ec[i], 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL right_result%0d: got v=%0b d=%h c=%0b id=%0b err=%0b, want v=1 d=%h c=%0b id=1 err=0",
                         i, out_valid, out_data, out_c, out_id, out_err, ed[i], ec[i]);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        edge_model();
    endtask

    task automatic test_alternation();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_in(1, 5'h0D, 5'd2, 32'h0000_00F0, 1, 5'h0C, 5'd3, 32'h0000_000F, 1);
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL alt_ready%0d: got %b, want %b", i, {req0_ready, req1_ready},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            edge_model();
            checks++;
            if ({out_valid, out_id, out_data} !== {1'b1, 1'(i % 2), (i % 2 == 0) ? 32'h0000_003C : 32'h0000_0078}) begin
                errors++;
                $display("[TB] FAIL alt_result%0d: got v=%0b id=%0b d=%h, want v=1 id=%0d", i,
                         out_valid, out_id, out_data, i % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] sd;
        logic        sc, sid, serr;
        @(negedge clk);
        set_in(1, 5'h0C, 5'd4, 32'h0000_1234, 1, 5'h0E, 5'd8, 32'hF000_0000, 1);
        edge_model();
        sd = out_data; sc = out_c; sid = out_id; serr = out_err;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL bp_ready%0d: got %b, want 00", i, {req0_ready, req1_ready});
            end
            edge_model();
            checks++;
            if ({out_valid, out_data, out_c, out_id, out_err} !== {1'b1, sd, sc, sid, serr}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got v=%0b d=%h id=%0b, want v=1 d=%h id=%0b",
                         i, out_valid, out_data, out_id, sd, sid);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== (sid ? 2'b10 : 2'b01)) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b, want %b", {req0_ready, req1_ready},
                     sid ? 2'b10 : 2'b01);
        end
        edge_model();
        checks++;
        if ({out_valid, out_id} !== {1'b1, ~sid}) begin
            errors++;
            $display("[TB] FAIL bp_release_result: got v=%0b id=%0b, want v=1 id=%0b",
                     out_valid, out_id, ~sid);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        edge_model();
    endtask

    task automatic test_illegal_fs();
        @(negedge clk);
        set_in(1, 5'h0F, 5'd3, 32'h1234_5678, 0, 0, 0, 0, 1);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_ready: got %b, want 1", req0_ready);
        end
        edge_model();
        checks++;
        if ({out_valid, out_data, out_c, out_err} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL illegal_result: got v=%0b d=%h c=%0b err=%0b, want v=1 d=0 c=0 err=1",
                     out_valid, out_data, out_c, out_err);
        end
        @(negedge clk);
        set_in(1, 5'h0C, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
        edge_model();
        checks++;
        if ({out_valid, out_data, out_c, out_err} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sll_zero: got v=%0b d=%h c=%0b err=%0b, want v=1 d=deadbeef c=0 err=0",
                     out_valid, out_data, out_c, out_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 5'h0D, 5'd1, 32'hFFFF_0000, 1);
        edge_model();
        @(negedge clk);
        set_in(1, 5'h0C, 5'd1, 32'h0000_0005, 1, 5'h0C, 5'd2, 32'h0000_0005, 0);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, out_c, out_id, out_err} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%0b d=%h c=%0b id=%0b err=%0b, want all zero",
                     out_valid, out_data, out_c, out_id, out_err);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL post_reset_grant: got %b, want 10", {req0_ready, req1_ready});
        end
        edge_model();
        checks++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b0, 32'h0000_000A}) begin
            errors++;
            $display("[TB] FAIL post_reset_result: got v=%0b id=%0b d=%h, want v=1 id=0 d=0000000a",
                     out_valid, out_id, out_data);
        end
    endtask

    function automatic logic [4:0] rand_fs();
        case ($urandom_range(0, 3))
            0: return 5'h0C;
            1: return 5'h0D;
            2: return 5'h0E;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic hold0, hold1;
        int   win;
        hold0 = 1'b0; hold1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!hold0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_fs = rand_fs(); req0_shamt = 5'($urandom); req0_data = $urandom;
            end
            if (!hold1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_fs = rand_fs(); req1_shamt = 5'($urandom); req1_data = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            win = model_winner();
            checks++;
            if ({req0_ready, req1_ready} !== {win == 0, win == 1}) begin
                errors++;
                $display("[TB] FAIL rand_ready%0d: got %b, want %b", i, {req0_ready, req1_ready},
                         {win == 0, win == 1});
            end
            hold0 = req0_valid && (win != 0);
            hold1 = req1_valid && (win != 1);
            edge_model();
            checks++;
            if (out_valid !== m_valid ||
                (m_valid && {out_data, out_c, out_id, out_err} !== {m_data, m_c, m_id, m_err})) begin
                errors++;
                $display("[TB] FAIL rand_out%0d: got v=%0b d=%h c=%0b id=%0b err=%0b, want v=%0b d=%h c=%0b id=%0b err=%0b",
                         i, out_valid, out_data, out_c, out_id, out_err,
                         m_valid, m_data, m_c, m_id, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        test_reset();
        test_sll();
        test_srl_sra();
        test_alternation();
        test_backpressure();
        test_illegal_fs();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath (SLL/SRL/SRA, FS codes 5'h0C/5'h0D/5'h0E) between two requesters, e.g. the integer execute stage (port 0) and the multi-cycle MUL/DIV sequencer (port 1).
- Round-robin arbitration with valid/ready handshakes on both request ports.
- Single registered output stage with backpressure.
- Sits between the issue logic and the writeback mux; the shift function is implemented inside this block.

Parameters:
- DW, 32, operand/result width (only 32 supported).
- SAW, 5, shift-amount width (log2 DW).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle when high with req0_valid.
- req0_fs  input  5  function select, requester 0.
- req0_shamt  input  SAW  shift amount, requester 0.
- req0_data  input  DW  operand T, requester 0.
- req1_valid, req1_ready, req1_fs, req1_shamt, req1_data: same as above, for requester 1.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts result.
- out_data  output  DW  shift result.
- out_c  output  1  carry flag.
- out_id  output  1  requester that issued the result (0/1).
- out_err  output  1  FS was not 0C/0D/0E.

Behaviour:
Reset (async, active-high):
- out_valid=0, out_data=0, out_c=0, out_id=0, out_err=0.
- Priority pointer ptr=0 (requester 0 favoured).
- Effective immediately, mid-transfer included. Any held result is discarded; no request is accepted while reset is high.

Output stage FSM (EMPTY/FULL, mirrored by out_valid):
- can_load = ~out_valid | out_ready.
- EMPTY -> FULL on accept. FULL -> EMPTY on out_ready with no accept. FULL -> FULL on out_ready plus accept: back-to-back, 1 result/cycle.
- While FULL and out_ready=0, out_data/out_c/out_id/out_err stay stable.

Arbitration (combinational):
- Only one valid: that requester is granted.
- Both valid: grant = ptr.
- reqN_ready = grantN & can_load. At most one ready high per cycle.
- A ready is never asserted for a non-valid requester.
- Requesters must not make valid depend on ready, and must hold fs/shamt/data stable while valid & ~ready.
- On accept, ptr <= ~(granted id), so the other requester wins the next contention. Worst-case wait is one accepted transfer.
- ptr does not change when nothing is accepted.

Latency:
- Accept at edge k: result visible on out_* after edge k (registered), with out_valid=1.
- No combinational path from req*_data to out_data.

Shift function (registered on accept; T=data, n=shamt):
- SLL (0C): out_data = T<<n, zero fill. out_c = T[32-n] for n>=1; 0 for n=0.
- SRL (0D): out_data = T>>n, zero fill. out_c = T[n-1] for n>=1; 0 for n=0.
- SRA (0E): out_data = T>>>n, T[31] fill. n=31 gives all bits = T[31]. out_c=0 always.
- Any other FS: out_data=0, out_c=0, out_err=1. The transfer is still accepted and returned, so requesters are never stalled.
- For legal FS, out_err=0.
- out_id = granted requester.

Test Plan:
- After reset, req0 SLL T=32'h8000_0001 n=1, out_ready=1 -> next cycle out_valid=1, out_data=32'h0000_0002, out_c=1, out_id=0. Separately, SLL T=32'h0000_0001 n=31 -> out_data=32'h8000_0000, out_c=0.
- req1 SRL T=32'h0000_0003 n=1 -> out_data=32'h0000_0001, out_c=1, out_id=1. Then SRA T=32'h8000_0000 n=31 -> out_data=32'hFFFF_FFFF, out_c=0. Then SRA T=32'h4000_0000 n=4 -> out_data=32'h0400_0000, out_c=0.
- Both valid continuously, out_ready=1, from reset -> grants alternate 0,1,0,1; one result per cycle; out_id sequence 0,1,0,1; never two readys in one cycle.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs stable; both readys low; ptr unchanged. Raise out_ready -> pending requester accepted the same cycle and its result appears the next cycle.
- req0 FS=5'h0F, T=32'h1234_5678 -> out_err=1, out_data=0, out_c=0, accepted normally. Then req0 SLL n=0 T=32'hDEAD_BEEF -> out_data=32'hDEAD_BEEF, out_c=0, out_err=0.
- Assert reset while out_valid=1 and out_ready=0 -> out_valid=0 immediately (asynchronous, before the next edge), all out_* zero. After release, the first contention grants requester 0.
